// File: rtl/bcd_pkg.sv
// Shared BCD definitions: converter FSM states and digit-count helper.
// Reused by the converter and by display drivers sizing digit buses.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } bcd_state_e;

  // 1233/4096 approximates log10(2), giving the decimal digit count.
  function automatic int bcd_digits(input int width);
    return ((width * 1233) >> 12) + 1;
  endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction cell: a digit of 5 or more gains 3.
// Purely combinational; no carry leaves the digit.
module bcd_add3_digit (
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'd5) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bin2bcd_double_dabble.sv
// Free-running serial binary-to-BCD converter (double dabble).
// One result every WIDTH+2 cycles, published with a one-cycle valid.
module bin2bcd_double_dabble
  import bcd_pkg::*;
#(
  parameter  int WIDTH  = 16,
  localparam int DIGITS = bcd_digits(WIDTH)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [WIDTH-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  bcd_valid
);

  localparam int CW = $clog2(WIDTH);
  localparam int SW = 4 * DIGITS;

  bcd_state_e       state_q;
  logic [WIDTH-1:0] sh_q;
  logic [WIDTH-1:0] sh_d;
  logic [SW-1:0]    scr_q;
  logic [SW-1:0]    scr_d;
  logic [SW-1:0]    adj;
  logic [CW-1:0]    cnt_q;
  logic [SW+WIDTH-1:0] cat_d;

  for (genvar k = 0; k < DIGITS; k++) begin : g_dig
    bcd_add3_digit u_add3 (
      .d_i (scr_q[4*k +: 4]),
      .d_o (adj[4*k +: 4])
    );
  end

  // Corrected scratch and binary shift together as one wide register.
  assign cat_d = {adj, sh_q} << 1;
  assign scr_d = cat_d[SW+WIDTH-1:WIDTH];
  assign sh_d  = cat_d[WIDTH-1:0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_LOAD;
      sh_q      <= '0;
      scr_q     <= '0;
      cnt_q     <= '0;
      bcd_out   <= '0;
      bcd_valid <= 1'b0;
    end else begin
      bcd_valid <= 1'b0;
      unique case (state_q)
        ST_LOAD: begin
          sh_q    <= bin_in;
          scr_q   <= '0;
          cnt_q   <= '0;
          state_q <= ST_SHIFT;
        end
        ST_SHIFT: begin
          sh_q  <= sh_d;
          scr_q <= scr_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1))
            state_q <= ST_DONE;
        end
        ST_DONE: begin
          bcd_out   <= scr_q;
          bcd_valid <= 1'b1;
          state_q   <= ST_LOAD;
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_double_dabble.sv
// Directed and random checks of the 16-bit double-dabble converter.
// Expected BCD values are queued at drive time and popped on bcd_valid.
module tb_bin2bcd_double_dabble;

  logic        clk;
  logic        nrst;
  logic [15:0] bin_in;
  logic [19:0] bcd_out;
  logic        bcd_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int last_valid = -1;
  logic [19:0] exp_q[$];

  bin2bcd_double_dabble #(16) dut (
    .clk       (clk),
    .nrst      (nrst),
    .bin_in    (bin_in),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r;
    int x;
    x = v;
    r = '0;
    for (int k = 0; k < 5; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit digits_ok(input logic [19:0] b);
    bit ok;
    ok = 1'b1;
    for (int k = 0; k < 5; k++)
      if (b[4*k +: 4] > 4'd9) ok = 1'b0;
    return ok;
  endfunction

  task automatic push(input int v);
    exp_q.push_back(to_bcd(v));
  endtask

  // Wait (bounded) for the next valid pulse and score it.
  task automatic take_result(input int exp_lat);
    int n;
    bit got;
    logic [19:0] e;
    n = 0;
    got = 1'b0;
    while (n < 40 && !got) begin
      @(posedge clk);
      #1;
      n++;
      got = bcd_valid;
    end
    n_cmp++;
    assert (got === 1'b1) else begin
      n_bad++;
      $error("FAIL valid_timeout got=%0b exp=1", got);
    end
    if (!got) return;
    if (exp_lat != 0) begin
      n_cmp++;
      assert (n === exp_lat) else begin
        n_bad++;
        $error("FAIL latency got=%0d exp=%0d", n, exp_lat);
      end
    end
    if (last_valid >= 0) begin
      n_cmp++;
      assert ((cyc - last_valid) === 18) else begin
        n_bad++;
        $error("FAIL spacing got=%0d exp=18", cyc - last_valid);
      end
    end
    last_valid = cyc;
    n_cmp++;
    assert (digits_ok(bcd_out) === 1'b1) else begin
      n_bad++;
      $error("FAIL digit_range got=%h exp=all<=9", bcd_out);
    end
    n_cmp++;
    assert (exp_q.size() > 0) else begin
      n_bad++;
      $error("FAIL unexpected_result got=%h exp=none", bcd_out);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      assert (bcd_out === e) else begin
        n_bad++;
        $error("FAIL bcd got=%h exp=%h", bcd_out, e);
      end
    end
  endtask

  initial begin
    nrst   = 1'b0;
    bin_in = 16'd23456;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    assert (bcd_out === 20'h0) else begin
      n_bad++;
      $error("FAIL rst_bcd got=%h exp=0", bcd_out);
    end
    n_cmp++;
    assert (bcd_valid === 1'b0) else begin
      n_bad++;
      $error("FAIL rst_valid got=%b exp=0", bcd_valid);
    end

    @(negedge clk);
    nrst = 1'b1;
    push(23456);
    take_result(18);

    // Next conversion resamples 23456; bin_in then changes mid-shift.
    push(23456);
    @(posedge clk);
    #1;
    n_cmp++;
    assert (bcd_valid === 1'b0) else begin
      n_bad++;
      $error("FAIL pulse_width got=%b exp=0", bcd_valid);
    end
    n_cmp++;
    assert (bcd_out === 20'h23456) else begin
      n_bad++;
      $error("FAIL hold got=%h exp=23456", bcd_out);
    end
    repeat (5) @(posedge clk);
    #1;
    bin_in = 16'd12623;
    push(12623);
    take_result(0);
    take_result(0);

    bin_in = 16'd0;     push(0);     take_result(18);
    bin_in = 16'd65535; push(65535); take_result(18);
    bin_in = 16'd9;     push(9);     take_result(18);
    bin_in = 16'd10;    push(10);    take_result(18);

    // Abort during SHIFT: outputs clear at once, nothing partial appears.
    bin_in = 16'd4321;
    push(4321);
    repeat (6) @(posedge clk);
    #1;
    nrst = 1'b0;
    #2;
    n_cmp++;
    assert (bcd_out === 20'h0) else begin
      n_bad++;
      $error("FAIL abort_bcd got=%h exp=0", bcd_out);
    end
    n_cmp++;
    assert (bcd_valid === 1'b0) else begin
      n_bad++;
      $error("FAIL abort_valid got=%b exp=0", bcd_valid);
    end
    exp_q.delete();
    last_valid = -1;
    @(negedge clk);
    nrst = 1'b1;
    push(4321);
    take_result(18);

    for (int i = 0; i < 1000; i++) begin
      bin_in = 16'($urandom_range(0, 65535));
      push(int'(bin_in));
      take_result(18);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
